// File: rtl/instruction_loader_pkg.sv
// Shared widths, end-of-program marker and FSM encoding for the
// instruction loader and the fetch stage it feeds.
package instruction_loader_pkg;

  localparam int INSTRUCTION_LENGTH = 32;
  localparam int PC_LENGTH = 32;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Packs bytes MSB-first into a word and watches for a stalled
// partial word.
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          capture,
  input  logic                          count_en,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [INSTRUCTION_LENGTH-1:0] word,
  output logic                          word_ready,
  output logic                          timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [INSTRUCTION_LENGTH-9:0] asm_q;
  logic [1:0]                    byte_idx;
  logic [TW-1:0]                 tcnt;
  logic                          take;
  logic                          stall;

  assign take = capture & rx_valid;
  assign stall = count_en & ~rx_valid
               & (byte_idx != 2'd0);

  // Word is offered on the edge its last byte arrives.
  assign word = {asm_q, rx_data};
  assign word_ready = take & (byte_idx == 2'd3);
  assign timeout = stall
    & (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q    <= '0;
      byte_idx <= '0;
      tcnt     <= '0;
    end else if (!capture) begin
      asm_q    <= '0;
      byte_idx <= '0;
      tcnt     <= '0;
    end else if (take) begin
      asm_q    <= {asm_q[INSTRUCTION_LENGTH-17:0], rx_data};
      byte_idx <= byte_idx + 2'd1;
      tcnt     <= '0;
    end else if (stall) begin
      tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a serial byte stream into instruction memory and gates the
// processor run enable until a HALT-terminated program is stored.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 64,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W = $clog2(MEM_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_start,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          run,
  output logic                          wr_memory_instruction_enable,
  output logic [INSTRUCTION_LENGTH-1:0] instruction_to_write,
  output logic [PC_LENGTH-1:0]          address_to_write,
  output logic                          mips_enable,
  output logic                          loading,
  output logic                          load_done,
  output logic                          load_error,
  output logic [CNT_W-1:0]              words_loaded
);

  state_t state, next_state;

  logic [INSTRUCTION_LENGTH-1:0] word;
  logic word_ready;
  logic timeout;
  logic start;
  logic full;
  logic mips_d;

  word_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .capture   ((state == RECV) | (state == WRITE)),
    .count_en  (state == RECV),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .word      (word),
    .word_ready(word_ready),
    .timeout   (timeout)
  );

  assign start = load_start
    & ((state == IDLE) | (state == DONE)
       | (state == ERROR));
  assign full = (words_loaded + CNT_W'(1))
    == CNT_W'(MEM_DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = RECV;
      RECV: begin
        if (timeout)         next_state = ERROR;
        else if (word_ready) next_state = WRITE;
      end
      WRITE: begin
        if (instruction_to_write == HALT_WORD)
          next_state = DONE;
        else if (full)
          next_state = ERROR;
        else
          next_state = RECV;
      end
      DONE:  if (start) next_state = RECV;
      ERROR: if (start) next_state = RECV;
      default: next_state = IDLE;
    endcase
  end

  // Run enable only while staying in DONE, so it can never
  // overlap a write strobe.
  always_comb begin
    mips_d = 1'b0;
    if (state == DONE && next_state == DONE)
      mips_d = run;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_memory_instruction_enable <= 1'b0;
      instruction_to_write         <= '0;
      address_to_write             <= '0;
      mips_enable                  <= 1'b0;
      loading                      <= 1'b0;
      load_done                    <= 1'b0;
      load_error                   <= 1'b0;
      words_loaded                 <= '0;
    end else begin
      wr_memory_instruction_enable <= next_state == WRITE;
      loading <= (next_state == RECV)
               | (next_state == WRITE);
      load_done   <= next_state == DONE;
      load_error  <= next_state == ERROR;
      mips_enable <= mips_d;
      if (word_ready && state == RECV)
        instruction_to_write <= word;
      if (start) begin
        address_to_write <= '0;
        words_loaded     <= '0;
      end else if (state == WRITE) begin
        address_to_write <= address_to_write + PC_LENGTH'(4);
        words_loaded     <= words_loaded + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Random and directed load sequences checked each cycle against a
// transaction-level loader model.
module tb_instruction_loader;

  localparam int DEPTH = 4;
  localparam int TO = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  localparam int M_IDLE = 0;
  localparam int M_RECV = 1;
  localparam int M_WRITE = 2;
  localparam int M_DONE = 3;
  localparam int M_ERR = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_start = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic run = 1'b0;
  logic wr;
  logic [31:0] instr;
  logic [31:0] addr;
  logic mips;
  logic loading;
  logic load_done;
  logic load_error;
  logic [CW-1:0] words_loaded;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  instruction_loader #(
    .MEM_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .run(run),
    .wr_memory_instruction_enable(wr),
    .instruction_to_write(instr),
    .address_to_write(addr),
    .mips_enable(mips),
    .loading(loading),
    .load_done(load_done),
    .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Behavioural model: bytes pile up in a queue until a word forms.
  int m_mode = M_IDLE;
  logic [7:0] q[$];
  int idle = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_addr = '0;
  int m_cnt = 0;
  bit m_mips = 1'b0;

  task automatic m_clear();
    m_mode = M_IDLE;
    q.delete();
    idle = 0;
    m_word = '0;
    m_addr = '0;
    m_cnt = 0;
    m_mips = 1'b0;
  endtask

  task automatic m_start();
    m_mode = M_RECV;
    q.delete();
    idle = 0;
    m_addr = '0;
    m_cnt = 0;
    m_mips = 1'b0;
  endtask

  always @(negedge reset) m_clear();

  always @(posedge clk) if (reset) begin
    case (m_mode)
      M_IDLE: if (load_start) m_start();
      M_RECV: begin
        if (rx_valid) begin
          q.push_back(rx_data);
          idle = 0;
          if (q.size() == 4) begin
            m_word = {q[0], q[1], q[2], q[3]};
            q.delete();
            m_mode = M_WRITE;
          end
        end else if (q.size() != 0) begin
          idle++;
          if (idle == TO) begin
            q.delete();
            m_mode = M_ERR;
          end
        end
      end
      M_WRITE: begin
        if (rx_valid) begin
          q.push_back(rx_data);
          idle = 0;
        end
        m_addr = m_addr + 4;
        m_cnt++;
        if (m_word == HALT) begin
          m_mode = M_DONE;
          q.delete();
        end else if (m_cnt == DEPTH) begin
          m_mode = M_ERR;
          q.delete();
        end else begin
          m_mode = M_RECV;
        end
      end
      M_DONE: if (load_start) m_start(); else m_mips = run;
      M_ERR: if (load_start) m_start();
      default: m_clear();
    endcase
  end

  always @(negedge clk) if (chk_on) begin
    logic e_wr, e_ld, e_dn, e_er;
    e_wr = m_mode == M_WRITE;
    e_ld = m_mode == M_RECV || m_mode == M_WRITE;
    e_dn = m_mode == M_DONE;
    e_er = m_mode == M_ERR;
    vectors++;
    if (wr !== e_wr || instr !== m_word || addr !== m_addr
        || mips !== m_mips || loading !== e_ld
        || load_done !== e_dn || load_error !== e_er
        || words_loaded !== CW'(m_cnt)) begin
      miscompares++;
      $display("FAIL cycle t=%0t got wr=%b ins=%h adr=%h mips=%b ld=%b dn=%b er=%b wl=%0d want wr=%b ins=%h adr=%h mips=%b ld=%b dn=%b er=%b wl=%0d",
        $time, wr, instr, addr, mips, loading, load_done,
        load_error, words_loaded, e_wr, m_word, m_addr,
        m_mips, e_ld, e_dn, e_er, m_cnt);
    end
    vectors++;
    if (wr && mips) begin
      miscompares++;
      $display("FAIL overlap t=%0t got wr=1 mips=1 want not both",
        $time);
    end
  end

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  always @(negedge clk) if (reset && wr) begin
    log_a.push_back(addr);
    log_d.push_back(instr);
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    cyc(1);
    load_start = 1'b0;
  endtask

  task automatic send(logic [7:0] b, int gap);
    rx_valid = 1'b1;
    rx_data = b;
    cyc(1);
    rx_valid = 1'b0;
    rx_data = $urandom;
    cyc(gap);
  endtask

  task automatic send_word(logic [31:0] w, int gap);
    for (int i = 3; i >= 0; i--)
      send(8'(w >> (8 * i)), gap);
  endtask

  task automatic wait_end(string name);
    int n;
    n = 0;
    while (!load_done && !load_error && n < 200) begin
      cyc(1);
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL %s_wait got no done/error want end within 200",
        name);
    end
  endtask

  task automatic chk_log(int i, logic [31:0] a,
                         logic [31:0] d);
    vectors++;
    if (log_a.size() <= i) begin
      miscompares++;
      $display("FAIL log%0d got %0d writes want > %0d", i,
        log_a.size(), i);
    end else begin
      chk($sformatf("addr%0d", i), log_a[i], a);
      chk($sformatf("data%0d", i), log_d[i], d);
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_out", {wr, mips, loading, load_done, load_error},
        32'd0);
    chk("rst_addr", addr, 32'd0);
    reset = 1'b1;
    cyc(1);
    chk_on = 1'b1;

    // Nominal program
    pulse_start();
    send_word(32'h2001_0005, 1);
    send_word(32'h2002_0007, 2);
    send_word(HALT, 0);
    wait_end("nominal");
    cyc(1);
    chk("nom_done", load_done, 32'd1);
    chk("nom_cnt", 32'(words_loaded), 32'd3);
    chk("nom_n", log_a.size(), 32'd3);
    chk_log(0, 32'h0, 32'h2001_0005);
    chk_log(1, 32'h4, 32'h2002_0007);
    chk_log(2, 32'h8, HALT);
    run = 1'b1;
    cyc(1);
    chk("run_lat", mips, 32'd1);
    run = 1'b0;
    cyc(2);

    // Stalled partial word
    log_a.delete();
    log_d.delete();
    pulse_start();
    send(8'h12, 0);
    send(8'h34, TO + 4);
    chk("to_err", load_error, 32'd1);
    chk("to_nowr", log_a.size(), 32'd0);
    pulse_start();
    send_word(32'hDEAD_BEEF, 0);
    send_word(HALT, 1);
    wait_end("reload");
    chk_log(0, 32'h0, 32'hDEAD_BEEF);

    // Memory full without HALT
    log_a.delete();
    log_d.delete();
    pulse_start();
    for (int i = 0; i < DEPTH; i++)
      send_word(32'h1000_0000 + i, 1);
    wait_end("ovf");
    cyc(1);
    chk("ovf_err", load_error, 32'd1);
    chk("ovf_cnt", 32'(words_loaded), 32'd4);
    chk("ovf_mips", mips, 32'd0);
    chk_log(3, 32'hC, 32'h1000_0003);

    // Reset in the middle of the second word
    log_a.delete();
    log_d.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send(8'(i + 1), 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst", {wr, mips, loading, load_done, load_error,
        27'(words_loaded)}, 32'd0);
    chk("mid_addr", addr, 32'd0);
    chk("mid_n", log_a.size(), 32'd1);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    log_a.delete();
    log_d.delete();

    // Back-to-back bytes across the write cycle
    pulse_start();
    send_word(32'h1122_3344, 0);
    send_word(HALT, 0);
    wait_end("b2b");
    chk_log(0, 32'h0, 32'h1122_3344);
    chk_log(1, 32'h4, HALT);

    // Reload while running
    run = 1'b1;
    cyc(2);
    chk("run_on", mips, 32'd1);
    pulse_start();
    chk("restart_mips", mips, 32'd0);
    run = 1'b0;
    send_word(HALT, 0);
    wait_end("restart");

    // Random programs
    for (int l = 0; l < 12; l++) begin
      int nw;
      pulse_start();
      nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++) begin
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = 32'h0;
        if (w == nw - 1 && $urandom_range(0, 2) != 0) v = HALT;
        for (int i = 3; i >= 0; i--) begin
          run = 1'($urandom);
          if ($urandom_range(0, 24) == 0)
            send(8'(v >> (8 * i)), TO + 1);
          else
            send(8'(v >> (8 * i)), $urandom_range(0, 2));
        end
      end
      for (int k = 0; k < 6; k++) begin
        run = 1'($urandom);
        cyc(1);
      end
    end
    run = 1'b0;
    cyc(3);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
